fifo_rr_drain: RTL and testbench

Round-robin drain stage that sits directly downstream of a bank of `NUM_FIFOS` FIFOs. It pops one word at a time from any non-empty FIFO and presents it on a single valid/ready output stream, tagged with the index of its source FIFO. It honours the FIFO read contract: one-cycle registered read data, registered EMPTY, and a read ignored when write is asserted in the same cycle.

---
 rtl/fifo_rr_drain.sv | 133 +++++++++++++
 tb/tb_fifo_rr_drain.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_drain.sv
// rtl/fifo_rr_drain.sv - round-robin drain of a FIFO bank onto one valid/ready stream
//
// Pops one word at a time from any non-empty upstream FIFO and presents it on
// OUT_DATA/OUT_VALID/OUT_READY, tagged with the source index on OUT_SRC.
//
// Ports:
//   CLK, RST_N     clock (rising edge) and asynchronous active-low reset
//   ENABLE         permits new grants; an in-flight transfer always completes
//   FIFO_EMPTY     per-FIFO registered EMPTY flags
//   FIFO_WR_EN     per-FIFO write-enable monitor (a read during a write is ignored)
//   FIFO_DOUT      packed FIFO read data, FIFO i in slice i
//   FIFO_RD_EN     one-hot read strobe, high only in the READ state
//   OUT_VALID      output word valid
//   OUT_READY      downstream accept
//   OUT_DATA       output word
//   OUT_SRC        index of the FIFO that supplied OUT_DATA
//   BUSY           high whenever the FSM is not idle
//   WORD_CNT       count of accepted output words, wraps at 16 bits
module fifo_rr_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_FIFOS  = 4,
  localparam int SRC_W     = $clog2(NUM_FIFOS)
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            ENABLE,
  input  logic [NUM_FIFOS-1:0]            FIFO_EMPTY,
  input  logic [NUM_FIFOS-1:0]            FIFO_WR_EN,
  input  logic [NUM_FIFOS*DATA_WIDTH-1:0] FIFO_DOUT,
  output logic [NUM_FIFOS-1:0]            FIFO_RD_EN,
  output logic                            OUT_VALID,
  input  logic                            OUT_READY,
  output logic [DATA_WIDTH-1:0]           OUT_DATA,
  output logic [SRC_W-1:0]                OUT_SRC,
  output logic                            BUSY,
  output logic [15:0]                     WORD_CNT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_CAPT = 2'd2,
    S_SEND = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [SRC_W-1:0] grant_q;
  logic [SRC_W-1:0] last_q;
  logic [SRC_W-1:0] pick;
  logic             any_elig;
  logic             start_grant;

  // Round-robin search starting one past the last accepted source.
  always_comb begin
    int               idx_i;
    logic [SRC_W-1:0] idx_s;
    idx_i    = 0;
    idx_s    = '0;
    pick     = '0;
    any_elig = 1'b0;
    for (int k = 0; k < NUM_FIFOS; k++) begin
      idx_i = (int'(last_q) + 1 + k) % NUM_FIFOS;
      idx_s = SRC_W'(idx_i);
      if (!any_elig && !FIFO_EMPTY[idx_s]) begin
        any_elig = 1'b1;
        pick     = idx_s;
      end
    end
  end

  assign start_grant = (state_q == S_IDLE) && ENABLE && any_elig;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_grant) state_d = S_READ;
      // A write in the same cycle makes the FIFO drop our read; go back
      // to IDLE without touching last_q so the same FIFO is retried first.
      S_READ: state_d = FIFO_WR_EN[grant_q] ? S_IDLE : S_CAPT;
      S_CAPT: state_d = S_SEND;
      S_SEND: if (OUT_READY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded purely from registered state, so no input reaches them
  // combinationally.
  always_comb begin
    FIFO_RD_EN = '0;
    if (state_q == S_READ) begin
      FIFO_RD_EN[grant_q] = 1'b1;
    end
    OUT_VALID = (state_q == S_SEND);
    BUSY      = (state_q != S_IDLE);
  end

  // Grant, round-robin pointer, output word and accepted-word counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      grant_q  <= '0;
      last_q   <= SRC_W'(NUM_FIFOS - 1);
      OUT_DATA <= '0;
      OUT_SRC  <= '0;
      WORD_CNT <= '0;
    end else begin
      if (start_grant) begin
        grant_q <= pick;
      end
      // Read data is registered in the FIFO, so it is valid one cycle
      // after the strobe.
      if (state_q == S_CAPT) begin
        OUT_DATA <= FIFO_DOUT[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        OUT_SRC  <= grant_q;
      end
      if (state_q == S_SEND && OUT_READY) begin
        WORD_CNT <= WORD_CNT + 16'd1;
        last_q   <= grant_q;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_drain.sv
// tb/tb_fifo_rr_drain.sv - directed self-checking bench for fifo_rr_drain
module tb_fifo_rr_drain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  fifo_empty = 4'hF;
  logic [3:0]  fifo_wr_en = 4'h0;
  logic [31:0] fifo_dout = 32'h0;
  logic [3:0]  fifo_rd_en;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        busy;
  logic [15:0] word_cnt;

  int total = 0;
  int bad = 0;

  // Upstream FIFO bank model: registered dout and EMPTY, read ignored on write.
  logic [7:0] mem [4][16];
  int         hd [4];
  int         tl [4];
  logic       flush = 1'b0;
  logic       inf0 = 1'b0;

  int rd_cnt [4];
  int rd_total = 0;
  int cyc = 0;

  fifo_rr_drain #(.DATA_WIDTH(8), .NUM_FIFOS(4)) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .ENABLE     (enable),
    .FIFO_EMPTY (fifo_empty),
    .FIFO_WR_EN (fifo_wr_en),
    .FIFO_DOUT  (fifo_dout),
    .FIFO_RD_EN (fifo_rd_en),
    .OUT_VALID  (out_valid),
    .OUT_READY  (out_ready),
    .OUT_DATA   (out_data),
    .OUT_SRC    (out_src),
    .BUSY       (busy),
    .WORD_CNT   (word_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (flush) begin
        hd[i] = tl[i];
      end else if (fifo_rd_en[i] && !fifo_wr_en[i]) begin
        if (inf0 && i == 0) begin
          fifo_dout[7:0] <= 8'hEE;
        end else if (hd[i] != tl[i]) begin
          fifo_dout[i*8 +: 8] <= mem[i][hd[i][3:0]];
          hd[i] = hd[i] + 1;
        end
      end
      fifo_empty[i] <= !(inf0 && i == 0) && (hd[i] == tl[i]);
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (fifo_rd_en[i]) begin
        rd_cnt[i] = rd_cnt[i] + 1;
        rd_total  = rd_total + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int f, input logic [7:0] v);
    mem[f][tl[f][3:0]] = v;
    tl[f] = tl[f] + 1;
  endtask

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst_n      = 1'b0;
    flush      = 1'b1;
    fifo_wr_en = 4'h0;
    enable     = 1'b1;
    out_ready  = rdy;
    inf0       = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_rd(input logic [3:0] mask, input string tag);
    int n;
    n = 0;
    while ((fifo_rd_en & mask) == 4'h0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if ((fifo_rd_en & mask) == 4'h0) chk(tag, 32'(fifo_rd_en), 32'(mask));
  endtask

  initial begin
    int prev_t;
    int rd0;
    int rdt;
    logic [7:0] exp_d;

    // Reset state: nothing eligible, nothing happens.
    do_reset(1'b1);
    rdt = rd_total;
    repeat (10) @(negedge clk);
    chk("rst_rd", 32'(rd_total - rdt), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(word_cnt), 32'd0);
    chk("rst_data_src", {22'd0, out_src, out_data}, 32'd0);

    // Round-robin order, 4 cycles per word.
    do_reset(1'b1);
    for (int f = 0; f < 4; f++) begin
      push(f, 8'((10 + f) << 4));
      push(f, 8'(((10 + f) << 4) | 1));
    end
    prev_t = 0;
    for (int n = 0; n < 8; n++) begin
      wait_valid("rr_timeout");
      exp_d = 8'(((10 + n % 4) << 4) | (n / 4));
      chk("rr_data", 32'(out_data), 32'(exp_d));
      chk("rr_src", 32'(out_src), 32'(n % 4));
      if (n > 0) chk("rr_gap", 32'(cyc - prev_t), 32'd4);
      prev_t = cyc;
      @(negedge clk);
    end
    chk("rr_cnt", 32'(word_cnt), 32'd8);

    // Backpressure: word held stable, single read pulse, count on accept only.
    do_reset(1'b0);
    rdt = rd_total;
    rd0 = rd_cnt[2];
    push(2, 8'h5A);
    wait_valid("bp_timeout");
    repeat (20) begin
      @(negedge clk);
      chk("bp_hold", {word_cnt, out_valid, 5'd0, out_src, out_data},
          {16'd0, 1'b1, 5'd0, 2'd2, 8'h5A});
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_off", 32'(out_valid), 32'd0);
    chk("bp_cnt", 32'(word_cnt), 32'd1);
    chk("bp_rd2", 32'(rd_cnt[2] - rd0), 32'd1);
    chk("bp_rd_all", 32'(rd_total - rdt), 32'd1);

    // Collision: read during write is retried on the same FIFO.
    do_reset(1'b1);
    fifo_wr_en = 4'b0010;
    push(1, 8'h11);
    push(2, 8'h22);
    wait_rd(4'b1111, "col_timeout");
    chk("col_rd1", 32'(fifo_rd_en), 32'b0010);
    @(negedge clk);
    chk("col_idle", {30'd0, busy, out_valid}, 32'd0);
    @(negedge clk);
    chk("col_retry", 32'(fifo_rd_en), 32'b0010);
    fifo_wr_en = 4'b0000;
    wait_valid("col_timeout2");
    chk("col_word1", {22'd0, out_src, out_data}, {22'd0, 2'd1, 8'h11});
    @(negedge clk);
    wait_valid("col_timeout3");
    chk("col_word2", {22'd0, out_src, out_data}, {22'd0, 2'd2, 8'h22});
    @(negedge clk);

    // ENABLE dropped during CAPT: word completes, no new grant until re-enabled.
    do_reset(1'b1);
    push(0, 8'h61);
    push(1, 8'h62);
    push(2, 8'h63);
    wait_rd(4'b0001, "en_timeout");
    @(negedge clk);
    enable = 1'b0;
    wait_valid("en_timeout2");
    chk("en_word0", {22'd0, out_src, out_data}, {22'd0, 2'd0, 8'h61});
    @(negedge clk);
    rdt = rd_total;
    repeat (10) @(negedge clk);
    chk("en_no_rd", 32'(rd_total - rdt), 32'd0);
    chk("en_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    wait_valid("en_timeout3");
    chk("en_word1", {22'd0, out_src, out_data}, {22'd0, 2'd1, 8'h62});
    @(negedge clk);

    // Reset during SEND clears at once; next grant restarts at FIFO 0.
    do_reset(1'b1);
    push(1, 8'h41);
    wait_valid("mr_timeout");
    chk("mr_word", {22'd0, out_src, out_data}, {22'd0, 2'd1, 8'h41});
    @(negedge clk);
    out_ready = 1'b0;
    push(2, 8'h52);
    push(0, 8'h50);
    push(3, 8'h53);
    wait_valid("mr_timeout2");
    chk("mr_send", {22'd0, out_src, out_data}, {22'd0, 2'd2, 8'h52});
    rst_n = 1'b0;
    #1;
    chk("mr_valid_async", 32'(out_valid), 32'd0);
    chk("mr_busy_async", 32'(busy), 32'd0);
    chk("mr_regs_async", {word_cnt, 6'd0, out_src, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    wait_rd(4'b1111, "mr_timeout3");
    chk("mr_next_grant", 32'(fifo_rd_en), 32'b0001);
    wait_valid("mr_timeout4");
    chk("mr_word0", {22'd0, out_src, out_data}, {22'd0, 2'd0, 8'h50});
    @(negedge clk);

    // WORD_CNT wraps after 65536 accepted words.
    do_reset(1'b1);
    inf0 = 1'b1;
    for (int n = 0; n < 65536; n++) begin
      wait_valid("wrap_timeout");
      if (n == 65535) chk("wrap_before", 32'(word_cnt), 32'd65535);
      @(negedge clk);
    end
    chk("wrap_cnt", 32'(word_cnt), 32'd0);
    enable = 1'b0;
    inf0 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
